sl_host_arbiter: RTL and testbench
==================================

# sl_host_arbiter

Round-robin arbiter and response router that shares the single host port of a same-latency interconnect tree among `N_HOST` requesters. It grants at most one request per cycle with bounded burst fairness, issues the request registered to the interconnect, and records the issuer in a fixed-depth tag pipe. Because the interconnect's round-trip latency is the constant `LATENCY`, no IDs travel through the tree. The block sits between the requesting masters and the root `sl21_cell`.

## Interface
- `N_HOST`, 4, number of requesters (2..8)
- `PAYLOAD_W`, 64, request payload width (address, write data and opcode, opaque to this block)
- `RDATA_W`, 32, response data width
- `LATENCY`, 8, fixed cycles from `ic_req_valid` to the matching `ic_res_valid` (≥1)
- `MAX_BURST`, 4, maximum consecutive grants to one owner while others wait (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `arb_en`  in  1  1 = new grants allowed; 0 = drain only
- `err_clr`  in  1  synchronous clear of `res_err`
- `h_req_valid`  in  N_HOST  per-host request valid
- `h_req_read`  in  N_HOST  per-host flag: request expects a response
- `h_req_payload`  in  N_HOST*PAYLOAD_W  host i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]
- `h_req_ready`  out  N_HOST  one-hot-or-zero grant (accept)
- `h_res_valid`  out  N_HOST  one-hot-or-zero response strobe
- `h_res_data`  out  RDATA_W  response data, broadcast to all hosts
- `ic_req_valid`  out  1  request to interconnect
- `ic_req_read`  out  1  forwarded read flag
- `ic_req_payload`  out  PAYLOAD_W  forwarded payload
- `ic_res_valid`  in  1  response from interconnect
- `ic_res_data`  in  RDATA_W  response data from interconnect
- `res_err`  out  1  sticky latency-mismatch flag
- `idle`  out  1  no response outstanding and no request issued this cycle

## Operation
- Arbitration is combinational within each cycle. A request is accepted when `h_req_ready[i] & h_req_valid[i]`. `h_req_ready` is 0 for every host while `arb_en`=0.
- State: `owner` (log2 N_HOST bits), `burst_cnt` (0..MAX_BURST), `owner_vld`.
- Hold rule: if `owner_vld`, `h_req_valid[owner]`=1 and `burst_cnt` < MAX_BURST, grant `owner`.
- Otherwise rotate: search (owner+1) mod N_HOST upward with wrap. The first valid host wins. That host becomes `owner`, `owner_vld` is set and `burst_cnt` is set to 1. The old owner can be re-picked only if it is the sole requester, and that restarts its count at 1.
- On a hold grant, `burst_cnt` increments. With no grant, `owner` is unchanged and `burst_cnt` is 0.
- On an accept, the payload, read flag and valid are registered into `ic_req_*`. The tag {read, host id} enters a `LATENCY`-deep shift pipe aligned to `ic_req_valid`.
- Response stage: the tag issued with `ic_req_valid` in cycle c is examined in cycle c+LATENCY.
  - Tag read=1 and `ic_res_valid`=1: `h_res_valid[id]`=1 and `h_res_data` = `ic_res_data`. Both are combinational from the inputs, with no added latency.
  - Tag read=1 and `ic_res_valid`=0: `res_err` is set. The response is lost and no `h_res_valid` fires.
  - No read tag and `ic_res_valid`=1: `res_err` is set and the data is dropped.
- `res_err` holds until `err_clr`. If a set event and `err_clr` occur in the same cycle, the set wins.
- `idle` = no valid tag in the pipe and `ic_req_valid`=0.
- Clearing `arb_en` mid-burst blocks grants from the next cycle. In-flight responses still route. `owner` and `burst_cnt` are frozen and resume when `arb_en` returns.

## Timing
- Request: accept in cycle t, `ic_req_valid` in t+1, response to the host in t+1+LATENCY. Throughput is 1 request per cycle.
- The pipe holds up to LATENCY outstanding requests. There is no backpressure from the interconnect and no full condition.
- Reset (async assert, sync deassert by the system) sets:
  - `ic_req_valid`, `ic_req_read` and `ic_req_payload` to 0
  - tag pipe empty, `owner`=N_HOST-1, `owner_vld`=0, `burst_cnt`=0
  - `res_err`=0, `idle`=1, `h_res_valid`=0, `h_res_data`=0
  
  With `owner`=N_HOST-1, host 0 has first priority after reset.
- Reset mid-operation discards all outstanding tags. Responses arriving after reset release are flagged by `res_err`.
- `h_req_ready` depends combinationally on `h_req_valid`, `arb_en` and state. It has no combinational path from `ic_res_*`.

## Test plan
- Single read: after reset, host 2 sends payload 0xA5 with read=1 in cycle 5. Required: `ic_req_valid` in cycle 6; `ic_res_valid` with data 0x1234 driven in cycle 14 gives `h_res_valid`=4'b0100 and `h_res_data`=0x1234 in cycle 14.
- Fairness: all 4 hosts request continuously with MAX_BURST=4. Required grant order is 0,0,0,0,1,1,1,1,2,... with back-to-back issue and no gaps.
- Early release: host 1 owns the grant and drops valid after 2 beats while host 3 is requesting. Required: host 3 is granted in the next cycle with `burst_cnt`=1.
- Pipelined mix: 8 back-to-back requests alternating hosts 0 and 3, read flags 1,0,1,0,... Required: exactly 4 responses, each routed to the correct host 8 cycles after issue. Writes produce no `h_res_valid`.
- Errors: `ic_res_valid` pulsed with no outstanding read, then a read whose response is withheld. Required: `res_err`=1 after the first event. `err_clr` clears it, and the missing response sets it again in cycle t+1+LATENCY.
- Drain: `arb_en` drops with 3 requests in flight. Required: no new `h_req_ready`, the 3 responses are delivered, and `idle` rises 1 cycle after the last one. Async reset during a burst empties the pipe and sets `idle`=1 immediately.

Source files
------------

// File: rtl/sl_host_arbiter.sv
// sl_host_arbiter
//   Shares the single host port of a fixed-latency interconnect tree among
//   N_HOST requesters. A round-robin arbiter with a per-owner burst limit
//   picks at most one request per cycle and forwards it registered to the
//   interconnect. Because every response returns exactly LATENCY cycles after
//   its request, the issuer is tracked by a tag shift pipe instead of an ID
//   carried through the tree.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   arb_en          : 1 = new grants allowed, 0 = drain in-flight work only
//   err_clr         : synchronous clear of res_err (a same-cycle set wins)
//   h_req_valid     : per-host request valid
//   h_req_read      : per-host "request expects a response" flag
//   h_req_payload   : host i at [i*PAYLOAD_W +: PAYLOAD_W], opaque payload
//   h_req_ready     : one-hot-or-zero grant, combinational
//   h_res_valid     : one-hot-or-zero response strobe, combinational
//   h_res_data      : response data broadcast to all hosts
//   ic_req_*        : registered request towards the interconnect
//   ic_res_*        : response from the interconnect
//   res_err         : sticky flag for a response/tag mismatch
//   idle            : nothing issued this cycle and nothing outstanding
module sl_host_arbiter #(
    parameter int N_HOST    = 4,
    parameter int PAYLOAD_W = 64,
    parameter int RDATA_W   = 32,
    parameter int LATENCY   = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arb_en,
    input  logic                        err_clr,
    input  logic [N_HOST-1:0]           h_req_valid,
    input  logic [N_HOST-1:0]           h_req_read,
    input  logic [N_HOST*PAYLOAD_W-1:0] h_req_payload,
    output logic [N_HOST-1:0]           h_req_ready,
    output logic [N_HOST-1:0]           h_res_valid,
    output logic [RDATA_W-1:0]          h_res_data,
    output logic                        ic_req_valid,
    output logic                        ic_req_read,
    output logic [PAYLOAD_W-1:0]        ic_req_payload,
    input  logic                        ic_res_valid,
    input  logic [RDATA_W-1:0]          ic_res_data,
    output logic                        res_err,
    output logic                        idle
);

    localparam int ID_W = $clog2(N_HOST);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] MAX_BC = BC_W'(MAX_BURST);

    typedef struct packed {
        logic            vld;
        logic            rd;
        logic [ID_W-1:0] id;
    } tag_t;

    logic [ID_W-1:0]      owner_q, owner_d;
    logic                 owner_vld_q, owner_vld_d;
    logic [BC_W-1:0]      burst_q, burst_d;
    logic                 ic_vld_q, ic_vld_d;
    logic                 ic_rd_q, ic_rd_d;
    logic [PAYLOAD_W-1:0] ic_pay_q, ic_pay_d;
    logic [ID_W-1:0]      issue_id_q, issue_id_d;
    logic                 err_q, err_d;
    tag_t                 tag_q [1:LATENCY];

    logic            hold;
    logic            rr_found;
    logic [ID_W-1:0] rr_id;
    logic [ID_W-1:0] rr_cand;
    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    tag_t            rsp_tag;
    logic            rd_due;
    logic            pipe_busy;

    // ------------------------------------------------------------------
    // Arbitration: keep the current owner while it still requests and has
    // burst budget left, otherwise scan upward from owner+1 with wrap so the
    // old owner is only re-picked when it is the sole requester.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        rr_found = 1'b0;
        rr_id    = owner_q;
        rr_cand  = '0;
        for (int k = 1; k <= N_HOST; k++) begin
            rr_cand = ID_W'((int'(owner_q) + k) % N_HOST);
            if (!rr_found && h_req_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_id    = rr_cand;
            end
        end

        hold      = owner_vld_q && h_req_valid[owner_q] && (burst_q < MAX_BC);
        grant_vld = arb_en && (hold || rr_found);
        grant_id  = hold ? owner_q : rr_id;

        h_req_ready = '0;
        if (grant_vld) h_req_ready = N_HOST'(1) << grant_id;
    end

    // Next state. With arb_en low the owner and burst count are frozen so a
    // burst resumes where it stopped.
    always_comb begin
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        burst_d     = burst_q;
        ic_vld_d    = 1'b0;
        ic_rd_d     = ic_rd_q;
        ic_pay_d    = ic_pay_q;
        issue_id_d  = issue_id_q;

        if (arb_en) begin
            if (hold) begin
                burst_d = burst_q + BC_W'(1);
            end else if (rr_found) begin
                owner_d     = rr_id;
                owner_vld_d = 1'b1;
                burst_d     = BC_W'(1);
            end else begin
                burst_d = '0;
            end
        end

        if (grant_vld) begin
            ic_vld_d   = 1'b1;
            ic_rd_d    = h_req_read[grant_id];
            ic_pay_d   = h_req_payload[grant_id*PAYLOAD_W +: PAYLOAD_W];
            issue_id_d = grant_id;
        end
    end

    // ------------------------------------------------------------------
    // Response stage: the tag issued with ic_req_valid in cycle c reaches
    // the last pipe stage in cycle c+LATENCY, exactly when its response is
    // due. Any disagreement between "read due" and ic_res_valid is an error.
    // ------------------------------------------------------------------
    always_comb begin
        rsp_tag     = tag_q[LATENCY];
        rd_due      = rsp_tag.vld & rsp_tag.rd;
        h_res_valid = '0;
        h_res_data  = '0;
        if (rd_due && ic_res_valid) begin
            h_res_valid = N_HOST'(1) << rsp_tag.id;
            h_res_data  = ic_res_data;
        end
        err_d = (rd_due ^ ic_res_valid) | (err_q & ~err_clr);

        pipe_busy = 1'b0;
        for (int k = 1; k <= LATENCY; k++) pipe_busy = pipe_busy | tag_q[k].vld;
        idle = ~ic_vld_q & ~pipe_busy;
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= ID_W'(N_HOST - 1);
            owner_vld_q <= 1'b0;
            burst_q     <= '0;
            ic_vld_q    <= 1'b0;
            ic_rd_q     <= 1'b0;
            ic_pay_q    <= '0;
            issue_id_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            burst_q     <= burst_d;
            ic_vld_q    <= ic_vld_d;
            ic_rd_q     <= ic_rd_d;
            ic_pay_q    <= ic_pay_d;
            issue_id_q  <= issue_id_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the tag pipe is reset despite being a register array, because a
    // stale valid tag after reset would route a phantom response and hold
    // idle low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= LATENCY; k++) tag_q[k] <= '0;
        end else begin
            tag_q[1] <= '{vld: ic_vld_q, rd: ic_rd_q, id: issue_id_q};
            for (int k = 2; k <= LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    assign ic_req_valid   = ic_vld_q;
    assign ic_req_read    = ic_rd_q;
    assign ic_req_payload = ic_pay_q;
    assign res_err        = err_q;

endmodule

// File: tb/tb_sl_host_arbiter.sv
module tb_sl_host_arbiter;

    localparam int N   = 4;
    localparam int PW  = 64;
    localparam int RW  = 32;
    localparam int LAT = 8;
    localparam int MB  = 4;

    typedef struct {
        int            host;
        logic [RW-1:0] data;
        int            due;
    } exp_t;

    typedef struct {
        logic [RW-1:0] data;
        int            due;
    } mdl_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            arb_en = 1'b0;
    logic            err_clr = 1'b0;
    logic [N-1:0]    h_req_valid = '0;
    logic [N-1:0]    h_req_read = '0;
    logic [PW-1:0]   pay [N];
    logic [N*PW-1:0] h_req_payload;
    logic [N-1:0]    h_req_ready;
    logic [N-1:0]    h_res_valid;
    logic [RW-1:0]   h_res_data;
    logic            ic_req_valid;
    logic            ic_req_read;
    logic [PW-1:0]   ic_req_payload;
    logic            ic_res_valid;
    logic [RW-1:0]   ic_res_data;
    logic            res_err;
    logic            idle;

    // Interconnect model and error injection.
    logic            model_vld = 1'b0;
    logic [RW-1:0]   model_data = '0;
    logic            inj_vld = 1'b0;
    logic [RW-1:0]   inj_data = '0;
    logic            withhold = 1'b0;
    mdl_t            mq [$];

    exp_t            exp_q [$];
    exp_t            mon_e;
    int              cyc = 0;
    int              checks = 0;
    int              failures = 0;

    assign h_req_payload = {pay[3], pay[2], pay[1], pay[0]};
    assign ic_res_valid  = model_vld | inj_vld;
    assign ic_res_data   = model_vld ? model_data : inj_data;

    sl_host_arbiter #(
        .N_HOST(N), .PAYLOAD_W(PW), .RDATA_W(RW), .LATENCY(LAT), .MAX_BURST(MB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .err_clr(err_clr),
        .h_req_valid(h_req_valid), .h_req_read(h_req_read),
        .h_req_payload(h_req_payload), .h_req_ready(h_req_ready),
        .h_res_valid(h_res_valid), .h_res_data(h_res_data),
        .ic_req_valid(ic_req_valid), .ic_req_read(ic_req_read),
        .ic_req_payload(ic_req_payload), .ic_res_valid(ic_res_valid),
        .ic_res_data(ic_res_data), .res_err(res_err), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [RW-1:0] data_fn(input logic [PW-1:0] p);
        return p[31:0] ^ p[63:32] ^ 32'h0000_1291;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) nxt();
    endtask

    task automatic auto_pay();
        for (int h = 0; h < N; h++) pay[h] = {32'(h + 1), 32'(cyc)};
    endtask

    // One arbitration cycle: check grant and ic_req_valid at the negedge,
    // record the expected response of a granted read, advance one cycle.
    task automatic step(input string tag, input logic [N-1:0] exp_rdy, input logic exp_icv);
        @(negedge clk);
        check({tag, "_rdy"}, h_req_ready, exp_rdy);
        check({tag, "_icv"}, ic_req_valid, exp_icv);
        for (int h = 0; h < N; h++) begin
            if (exp_rdy[h] && h_req_read[h] && !withhold)
                exp_q.push_back('{host: h, data: data_fn(pay[h]), due: cyc + 1 + LAT});
        end
        nxt();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            nxt();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        h_req_valid = '0;
        exp_q.delete();
        nxt();
        nxt();
        rst_n = 1'b1;
    endtask

    // Interconnect: a read seen in cycle c is answered in cycle c+LAT.
    always @(negedge clk) begin
        if (!rst_n) mq.delete();
        else if (ic_req_valid && ic_req_read && !withhold)
            mq.push_back('{data: data_fn(ic_req_payload), due: cyc + LAT});
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && mq.size() > 0 && mq[0].due == cyc) begin
            model_vld  = 1'b1;
            model_data = mq[0].data;
            mq.delete(0);
        end else begin
            model_vld  = 1'b0;
            model_data = '0;
        end
    end

    // Scoreboard: every host response must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check("res_missing_cycle", cyc, exp_q[0].due);
                exp_q.delete(0);
            end
            if (h_res_valid !== '0) begin
                if (exp_q.size() == 0) begin
                    check("res_unexpected", h_res_valid, '0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("res_host", h_res_valid, N'(1) << mon_e.host);
                    check("res_data", h_res_data, mon_e.data);
                    check("res_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int t2;
        for (int h = 0; h < N; h++) pay[h] = '0;
        arb_en = 1'b1;

        // Reset values.
        @(negedge clk);
        check("rst_icv", ic_req_valid, 0);
        check("rst_icrd", ic_req_read, 0);
        check("rst_icpay", ic_req_payload, 0);
        check("rst_idle", idle, 1);
        check("rst_err", res_err, 0);
        check("rst_resv", h_res_valid, 0);
        check("rst_resd", h_res_data, 0);
        check("rst_rdy", h_req_ready, 0);
        nxt();
        rst_n = 1'b1;

        // Single read from host 2.
        h_req_valid = 4'b0100;
        h_req_read  = 4'b0100;
        pay[2]      = 64'hA5;
        t = cyc;
        step("single", 4'b0100, 1'b0);
        h_req_valid = '0;
        @(negedge clk);
        check("single_icv", ic_req_valid, 1);
        check("single_icpay", ic_req_payload, 64'hA5);
        check("single_icrd", ic_req_read, 1);
        check("single_busy", idle, 0);
        wait_cyc(t + 1 + LAT);
        @(negedge clk);
        check("single_resv", h_res_valid, 4'b0100);
        check("single_resd", h_res_data, 32'h1234);
        nxt();
        @(negedge clk);
        check("single_idle", idle, 1);
        check("single_err", res_err, 0);
        nxt();

        // Fairness: all hosts request, bursts of MB.
        do_reset();
        for (int i = 0; i < 4 * N; i++) begin
            h_req_valid = 4'b1111;
            h_req_read  = 4'b1111;
            auto_pay();
            step("fair", N'(1) << (i / MB), i > 0);
        end
        h_req_valid = '0;
        wait_drain("fair_drain");

        // Early release: host 1 drops after 2 beats, host 3 takes over with
        // a fresh burst count of 1 (so 4 grants before host 0 gets in).
        h_req_read = '0;
        auto_pay();
        h_req_valid = 4'b0010; step("early1", 4'b0010, 1'b0);
        h_req_valid = 4'b1010; step("early2", 4'b0010, 1'b1);
        h_req_valid = 4'b1000; step("early3", 4'b1000, 1'b1);
        h_req_valid = 4'b1001; step("early4", 4'b1000, 1'b1);
        step("early5", 4'b1000, 1'b1);
        step("early6", 4'b1000, 1'b1);
        step("early7", 4'b0001, 1'b1);
        h_req_valid = '0;
        nxt();
        nxt();

        // Pipelined mix: hosts 0 and 3 alternate, host 0 reads, host 3 writes.
        for (int k = 0; k < 8; k++) begin
            auto_pay();
            h_req_valid = (k % 2 == 0) ? 4'b0001 : 4'b1000;
            h_req_read  = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            step("mix", h_req_valid, k > 0);
        end
        h_req_valid = '0;
        wait_drain("mix_drain");
        nxt();

        // Errors: stray response, clear, withheld read, set-vs-clear priority.
        inj_vld  = 1'b1;
        inj_data = 32'hDEAD;
        @(negedge clk);
        check("err_stray_resv", h_res_valid, 0);
        check("err_stray_pre", res_err, 0);
        nxt();
        inj_vld = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        check("err_stray_set", res_err, 1);
        nxt();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_cleared", res_err, 0);
        nxt();
        withhold    = 1'b1;
        h_req_valid = 4'b0010;
        h_req_read  = 4'b0010;
        auto_pay();
        t = cyc;
        step("err_rd", 4'b0010, 1'b0);
        h_req_valid = '0;
        wait_cyc(t + LAT);
        @(negedge clk);
        check("err_miss_early", res_err, 0);
        nxt();
        @(negedge clk);
        check("err_miss_resv", h_res_valid, 0);
        check("err_miss_due", res_err, 0);
        nxt();
        @(negedge clk);
        check("err_miss_set", res_err, 1);
        nxt();
        withhold = 1'b0;
        inj_vld  = 1'b1;
        err_clr  = 1'b1;
        @(negedge clk);
        check("err_both_pre", res_err, 1);
        nxt();
        inj_vld = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        check("err_set_wins", res_err, 1);
        nxt();
        err_clr = 1'b1;
        nxt();
        err_clr = 1'b0;
        @(negedge clk);
        check("err_final_clr", res_err, 0);
        nxt();

        // Drain: three reads in flight, then arb_en drops.
        h_req_read = 4'b1111;
        auto_pay();
        h_req_valid = 4'b0001; step("drn0", 4'b0001, 1'b0);
        h_req_valid = 4'b0010; step("drn1", 4'b0010, 1'b1);
        t2 = cyc;
        h_req_valid = 4'b0100; step("drn2", 4'b0100, 1'b1);
        arb_en      = 1'b0;
        h_req_valid = 4'b1111;
        h_req_read  = 4'b0000;
        step("drn_blk", 4'b0000, 1'b1);
        while (cyc < t2 + 1 + LAT) step("drn_blk", 4'b0000, 1'b0);
        @(negedge clk);
        check("drn_last_resv", h_res_valid, 4'b0100);
        check("drn_last_busy", idle, 0);
        check("drn_last_rdy", h_req_ready, 0);
        nxt();
        @(negedge clk);
        check("drn_idle", idle, 1);
        check("drn_err", res_err, 0);
        nxt();
        // Resume: host 2 had used 1 of its burst, so 3 more grants.
        arb_en = 1'b1;
        step("resume1", 4'b0100, 1'b0);
        step("resume2", 4'b0100, 1'b1);
        step("resume3", 4'b0100, 1'b1);
        step("resume4", 4'b1000, 1'b1);

        // Async reset in the middle of a read burst.
        h_req_valid = 4'b0001;
        h_req_read  = 4'b0001;
        auto_pay();
        step("rstb1", 4'b0001, 1'b1);
        step("rstb2", 4'b0001, 1'b1);
        step("rstb3", 4'b0001, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_idle", idle, 1);
        check("arst_icv", ic_req_valid, 0);
        check("arst_icpay", ic_req_payload, 0);
        check("arst_resv", h_res_valid, 0);
        exp_q.delete();
        h_req_valid = '0;
        nxt();
        nxt();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", idle, 1);
            check("post_rst_err", res_err, 0);
            nxt();
        end

        check("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
